// File: rtl/complete_stage_pkg.sv
// Shared types for the complete stage.
// EX result bundle, CDB broadcast bundle, widths.
package complete_stage_pkg;

    localparam int XLEN         = 32;
    localparam int ROB_TAG_W    = 5;
    localparam int REG_IDX_W    = 5;
    localparam int CP_DEPTH_DEF = 4;

    typedef struct packed {
        logic [XLEN-1:0]      alu_result;
        logic                 take_branch;
        logic [XLEN-1:0]      NPC;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [REG_IDX_W-1:0] dest_reg_idx;
    } EX_PACKET;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]      value;
        logic                 dest_valid;
        logic [REG_IDX_W-1:0] dest_reg_idx;
        logic                 take_branch;
        logic [XLEN-1:0]      branch_target;
    } CDB_PACKET;

endpackage

// File: rtl/cp_fifo.sv
// Generic in-order FIFO with flush and occupancy count.
// No bypass: a push while full is refused even if a pop happens.
module cp_fifo #(
    parameter type T          = logic [31:0],
    parameter int  DEPTH      = 4,
    localparam int CNT_W      = $clog2(DEPTH + 1),
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  T                 wdata,
    output T                 rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cp_fifo: DEPTH must be a power of two >= 2");
    end

    T                 mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[head];

    // Pointer and occupancy bookkeeping; flush beats push/pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are qualified by count, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[tail] <= wdata;
        end
    end

endmodule

// File: rtl/complete_stage.sv
// Complete stage: buffers EX results in order and
// broadcasts one per cycle on the CDB.
module complete_stage
    import complete_stage_pkg::*;
#(
    parameter int  CP_DEPTH = CP_DEPTH_DEF,
    localparam int CNT_W    = $clog2(CP_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  EX_PACKET         ex_packet_in,
    input  logic             ex_valid,
    input  logic             ex_no_output,
    input  logic             cdb_grant,
    output logic             cdb_valid,
    output CDB_PACKET        cdb_packet,
    output logic             cp_full,
    output logic [CNT_W-1:0] cp_count,
    output logic             cp_overflow
);

    CDB_PACKET cp_entry;
    CDB_PACKET head_entry;
    logic      fifo_empty;
    logic      npc_unused;

    assign npc_unused = ^ex_packet_in.NPC;

    // Translate the EX result into its CDB form before buffering.
    always_comb begin
        cp_entry               = '0;
        cp_entry.rob_tag       = ex_packet_in.rob_tag;
        cp_entry.value         = ex_packet_in.alu_result;
        cp_entry.dest_valid    = ~ex_no_output;
        cp_entry.dest_reg_idx  = ex_packet_in.dest_reg_idx;
        cp_entry.take_branch   = ex_packet_in.take_branch;
        cp_entry.branch_target = ex_packet_in.alu_result;
    end

    cp_fifo #(
        .T     (CDB_PACKET),
        .DEPTH (CP_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (squash),
        .push  (ex_valid),
        .pop   (cdb_grant),
        .wdata (cp_entry),
        .rdata (head_entry),
        .count (cp_count),
        .full  (cp_full),
        .empty (fifo_empty)
    );

    // Broadcast the head entry; zeros when nothing is held.
    always_comb begin
        cdb_valid  = ~fifo_empty;
        cdb_packet = '0;
        if (!fifo_empty) begin
            cdb_packet = head_entry;
        end
    end

    // Sticky flag: a result arrived while the buffer was full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cp_overflow <= 1'b0;
        end else if (ex_valid && cp_full && !squash) begin
            cp_overflow <= 1'b1;
        end
    end

endmodule
